// File: rtl/mst_req_arb.sv
// Round-robin arbiter funnelling N upstream requesters into one mst_fsm port,
// one transaction in flight. Define MST_REQ_ARB_PRIO0_EN to give requester 0 fixed priority.
module mst_req_arb #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32,
   parameter int N          = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N-1:0]            req_vld,
   output logic [N-1:0]            req_rdy,
   input  logic [N-1:0]            rd_en,
   input  logic [N-1:0]            wr_en,
   input  logic [N*ADDR_WIDTH-1:0] addr,
   input  logic [N*DATA_WIDTH-1:0] wr_data,
   output logic [N-1:0]            ack_vld,
   input  logic [N-1:0]            ack_rdy,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    req_vld_m,
   input  logic                    req_rdy_m,
   output logic                    rd_en_m,
   output logic                    wr_en_m,
   output logic [ADDR_WIDTH-1:0]   addr_m,
   output logic [DATA_WIDTH-1:0]   wr_data_m,
   input  logic                    ack_vld_m,
   output logic                    ack_rdy_m,
   input  logic [DATA_WIDTH-1:0]   rd_data_m,
   output logic [3:0]              grant_id,
   output logic                    busy
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

   state_t                  r_state;
   logic [3:0]              r_ptr;
   logic [3:0]              r_gid;
   logic                    r_req_vld_m;
   logic                    r_rd_en_m;
   logic                    r_wr_en_m;
   logic [ADDR_WIDTH-1:0]   r_addr_m;
   logic [DATA_WIDTH-1:0]   r_wr_data_m;

   logic [N-1:0]            w_cand;
   logic [2*N-1:0]          w_rot;
   logic [5:0]              w_off;
   logic [5:0]              w_sum;
   logic [3:0]              w_win;
   logic                    w_any;
   logic [N-1:0]            w_win_oh;
   logic [N-1:0]            w_gnt_oh;
   logic                    w_rd_sel;
   logic                    w_wr_sel;
   logic [ADDR_WIDTH-1:0]   w_addr_sel;
   logic [DATA_WIDTH-1:0]   w_wdata_sel;
   logic                    w_ack_rdy_g;
   logic [3:0]              w_next_ptr;

   // Rotate a doubled request vector by ptr; the lowest set bit is the
   // distance from ptr to the winner, so no modulo search loop is needed.
   always_comb begin
      w_cand = req_vld;
`ifdef MST_REQ_ARB_PRIO0_EN
      w_cand[0] = 1'b0;
`endif
      w_rot = {w_cand, w_cand} >> r_ptr;
      w_off = '0;
      for (int j = 2*N-1; j >= 0; j--) begin
         if (w_rot[j]) w_off = 6'(j);
      end
      w_sum = {2'b00, r_ptr} + w_off;
      if (w_sum >= 6'(N)) w_sum = w_sum - 6'(N);
      w_win = w_sum[3:0];
`ifdef MST_REQ_ARB_PRIO0_EN
      if (req_vld[0]) w_win = 4'd0;
`endif
   end

   assign w_any = |req_vld;

   always_comb begin
      w_win_oh    = '0;
      w_gnt_oh    = '0;
      w_addr_sel  = '0;
      w_wdata_sel = '0;
      for (int i = 0; i < N; i++) begin
         w_win_oh[i] = (4'(i) == w_win);
         w_gnt_oh[i] = (4'(i) == r_gid);
         if (4'(i) == w_win) begin
            w_addr_sel  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_wdata_sel = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_rd_sel    = |(rd_en & w_win_oh);
   assign w_wr_sel    = |(wr_en & w_win_oh);
   assign w_ack_rdy_g = |(ack_rdy & w_gnt_oh);
   assign w_next_ptr  = (r_gid == 4'(N-1)) ? 4'd0 : r_gid + 4'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_gid       <= '0;
         r_req_vld_m <= 1'b0;
         r_rd_en_m   <= 1'b0;
         r_wr_en_m   <= 1'b0;
         r_addr_m    <= '0;
         r_wr_data_m <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_any) begin
               r_state     <= S_REQ;
               r_gid       <= w_win;
               r_req_vld_m <= 1'b1;
               r_rd_en_m   <= w_rd_sel;
               r_wr_en_m   <= w_wr_sel;
               r_addr_m    <= w_addr_sel;
               r_wr_data_m <= w_wdata_sel;
            end
            S_REQ: if (req_rdy_m) begin
               r_state     <= S_ACK;
               r_req_vld_m <= 1'b0;
            end
            S_ACK: if (ack_vld_m && w_ack_rdy_g) begin
               r_state <= S_IDLE;
               r_ptr   <= w_next_ptr;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Upstream handshakes are gated by rst so nothing leaks out while reset is held.
   assign req_rdy   = (r_state == S_IDLE && !rst && w_any) ? w_win_oh : '0;
   assign ack_vld   = (r_state == S_ACK && !rst && ack_vld_m) ? w_gnt_oh : '0;
   assign ack_rdy_m = (r_state == S_ACK) && !rst && w_ack_rdy_g;
   assign rd_data   = rd_data_m;
   assign req_vld_m = r_req_vld_m;
   assign rd_en_m   = r_rd_en_m;
   assign wr_en_m   = r_wr_en_m;
   assign addr_m    = r_addr_m;
   assign wr_data_m = r_wr_data_m;
   assign grant_id  = r_gid;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mst_req_arb.sv
// Directed bench for mst_req_arb (N=4, default build without priority).
module tb_mst_req_arb;
   localparam int AW = 64;
   localparam int DW = 32;
   localparam int N  = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_vld, req_rdy, rd_en, wr_en, ack_vld, ack_rdy;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wr_data;
   logic [DW-1:0]   rd_data, rd_data_m, wr_data_m;
   logic            req_vld_m, req_rdy_m, rd_en_m, wr_en_m, ack_vld_m, ack_rdy_m, busy;
   logic [AW-1:0]   addr_m;
   logic [3:0]      grant_id;

   int n_chk = 0;
   int n_err = 0;

   mst_req_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N(N)) dut (
      .clk(clk), .rst(rst),
      .req_vld(req_vld), .req_rdy(req_rdy), .rd_en(rd_en), .wr_en(wr_en),
      .addr(addr), .wr_data(wr_data),
      .ack_vld(ack_vld), .ack_rdy(ack_rdy), .rd_data(rd_data),
      .req_vld_m(req_vld_m), .req_rdy_m(req_rdy_m),
      .rd_en_m(rd_en_m), .wr_en_m(wr_en_m), .addr_m(addr_m), .wr_data_m(wr_data_m),
      .ack_vld_m(ack_vld_m), .ack_rdy_m(ack_rdy_m), .rd_data_m(rd_data_m),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clr_inputs();
      req_vld = '0; rd_en = '0; wr_en = '0; addr = '0; wr_data = '0;
      ack_rdy = '0; req_rdy_m = 1'b0; ack_vld_m = 1'b0; rd_data_m = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clr_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clr_inputs();
      rst = 1'b1;
      req_vld = 4'b0100; wr_en = 4'b0100; addr[2*AW +: AW] = 64'h55;
      @(negedge clk); @(negedge clk);
      #1;
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0h exp=0", busy); end
      n_chk++; if (grant_id !== 4'd0) begin n_err++; $display("FAIL reset_grant got=%0h exp=0", grant_id); end
      n_chk++; if (req_vld_m !== 1'b0) begin n_err++; $display("FAIL reset_req_vld_m got=%0h exp=0", req_vld_m); end
      n_chk++; if (addr_m !== 64'h0) begin n_err++; $display("FAIL reset_addr_m got=%0h exp=0", addr_m); end
      n_chk++; if (wr_en_m !== 1'b0) begin n_err++; $display("FAIL reset_wr_en_m got=%0h exp=0", wr_en_m); end
      n_chk++; if (req_rdy !== 4'b0) begin n_err++; $display("FAIL reset_req_rdy got=%0h exp=0", req_rdy); end
      n_chk++; if (ack_vld !== 4'b0) begin n_err++; $display("FAIL reset_ack_vld got=%0h exp=0", ack_vld); end
      n_chk++; if (ack_rdy_m !== 1'b0) begin n_err++; $display("FAIL reset_ack_rdy_m got=%0h exp=0", ack_rdy_m); end
      rst = 1'b0;
      clr_inputs();
      @(negedge clk);
   endtask

   task automatic test_single();
      do_reset();
      req_vld = 4'b0100; wr_en = 4'b0100;
      addr[2*AW +: AW] = 64'h40; wr_data[2*DW +: DW] = 32'hA5A5A5A5;
      #1;
      n_chk++; if (req_rdy !== 4'b0100) begin n_err++; $display("FAIL single_req_rdy got=%0h exp=4", req_rdy); end
      @(negedge clk);
      req_vld = '0;
      #1;
      n_chk++; if (req_vld_m !== 1'b1) begin n_err++; $display("FAIL single_req_vld_m got=%0h exp=1", req_vld_m); end
      n_chk++; if (addr_m !== 64'h40) begin n_err++; $display("FAIL single_addr_m got=%0h exp=40", addr_m); end
      n_chk++; if (wr_data_m !== 32'hA5A5A5A5) begin n_err++; $display("FAIL single_wr_data_m got=%0h exp=a5a5a5a5", wr_data_m); end
      n_chk++; if ({wr_en_m, rd_en_m} !== 2'b10) begin n_err++; $display("FAIL single_en got=%0h exp=2", {wr_en_m, rd_en_m}); end
      n_chk++; if (grant_id !== 4'd2) begin n_err++; $display("FAIL single_grant got=%0h exp=2", grant_id); end
      n_chk++; if (req_rdy !== 4'b0) begin n_err++; $display("FAIL single_req_rdy_pulse got=%0h exp=0", req_rdy); end
      n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got=%0h exp=1", busy); end
      req_rdy_m = 1'b1;
      @(negedge clk);
      req_rdy_m = 1'b0;
      ack_vld_m = 1'b1; ack_rdy = 4'b0100;
      #1;
      n_chk++; if (req_vld_m !== 1'b0) begin n_err++; $display("FAIL single_req_vld_m_drop got=%0h exp=0", req_vld_m); end
      n_chk++; if (ack_vld !== 4'b0100) begin n_err++; $display("FAIL single_ack_vld got=%0h exp=4", ack_vld); end
      n_chk++; if (ack_rdy_m !== 1'b1) begin n_err++; $display("FAIL single_ack_rdy_m got=%0h exp=1", ack_rdy_m); end
      @(negedge clk);
      ack_vld_m = 1'b0; ack_rdy = '0;
      #1;
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle got=%0h exp=0", busy); end
   endtask

   // Drives grants with all of `mask` requesting and checks the expected owner order.
   task automatic test_order(input logic [N-1:0] mask, input int cnt, input int e0,
                             input int e1, input int e2, input int e3, input int e4, input string nm);
      int exp_g [5];
      exp_g = '{e0, e1, e2, e3, e4};
      do_reset();
      req_vld = mask;
      for (int t = 0; t < cnt; t++) begin
         #1;
         n_chk++; if (req_rdy !== 4'(1 << exp_g[t])) begin n_err++; $display("FAIL %s_req_rdy[%0d] got=%0h exp=%0h", nm, t, req_rdy, 4'(1 << exp_g[t])); end
         @(negedge clk);
         n_chk++; if (grant_id !== 4'(exp_g[t])) begin n_err++; $display("FAIL %s_grant[%0d] got=%0d exp=%0d", nm, t, grant_id, exp_g[t]); end
         req_rdy_m = 1'b1;
         @(negedge clk);
         req_rdy_m = 1'b0; ack_vld_m = 1'b1; ack_rdy = 4'hF;
         @(negedge clk);
         ack_vld_m = 1'b0; ack_rdy = '0;
         n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_bubble[%0d] got=%0h exp=0", nm, t, busy); end
      end
      req_vld = '0;
      @(negedge clk);
   endtask

   task automatic test_stall();
      do_reset();
      req_vld = 4'b0010; addr[1*AW +: AW] = 64'h1234;
      @(negedge clk);
      addr[1*AW +: AW] = 64'hFF;
      ack_vld_m = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_chk++; if (req_vld_m !== 1'b1) begin n_err++; $display("FAIL stall_req_vld_m[%0d] got=%0h exp=1", c, req_vld_m); end
         n_chk++; if (addr_m !== 64'h1234) begin n_err++; $display("FAIL stall_addr_m[%0d] got=%0h exp=1234", c, addr_m); end
         n_chk++; if (req_rdy !== 4'b0 || ack_vld !== 4'b0) begin n_err++; $display("FAIL stall_upstream[%0d] got=%0h/%0h exp=0/0", c, req_rdy, ack_vld); end
         @(negedge clk);
      end
      ack_vld_m = 1'b0; req_vld = '0; req_rdy_m = 1'b1;
      @(negedge clk);
      req_rdy_m = 1'b0;
      n_chk++; if (busy !== 1'b1 || req_vld_m !== 1'b0) begin n_err++; $display("FAIL stall_to_ack got=%0h/%0h exp=1/0", busy, req_vld_m); end
      ack_vld_m = 1'b1; ack_rdy = 4'b0010;
      @(negedge clk);
      ack_vld_m = 1'b0; ack_rdy = '0;
   endtask

   task automatic test_read_ack_stall();
      do_reset();
      req_vld = 4'b0010; rd_en = 4'b0010;
      @(negedge clk);
      req_vld = '0; rd_en = '0;
      n_chk++; if ({rd_en_m, wr_en_m} !== 2'b10) begin n_err++; $display("FAIL read_en got=%0h exp=2", {rd_en_m, wr_en_m}); end
      req_rdy_m = 1'b1;
      @(negedge clk);
      req_rdy_m = 1'b0; ack_vld_m = 1'b1; rd_data_m = 32'hDEADBEEF; ack_rdy = 4'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_chk++; if (ack_vld !== 4'b0010) begin n_err++; $display("FAIL read_ack_vld[%0d] got=%0h exp=2", c, ack_vld); end
         n_chk++; if (rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_rd_data[%0d] got=%0h exp=deadbeef", c, rd_data); end
         n_chk++; if (ack_rdy_m !== 1'b0) begin n_err++; $display("FAIL read_ack_rdy_m_low[%0d] got=%0h exp=0", c, ack_rdy_m); end
         @(negedge clk);
         n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL read_hold[%0d] got=%0h exp=1", c, busy); end
      end
      ack_rdy = 4'b0010;
      #1;
      n_chk++; if (ack_rdy_m !== 1'b1) begin n_err++; $display("FAIL read_ack_rdy_m got=%0h exp=1", ack_rdy_m); end
      @(negedge clk);
      ack_vld_m = 1'b0; ack_rdy = '0;
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL read_idle got=%0h exp=0", busy); end
      req_vld = 4'hF;
      #1;
      n_chk++; if (req_rdy !== 4'b0100) begin n_err++; $display("FAIL read_ptr2 got=%0h exp=4", req_rdy); end
      req_vld = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_vld = 4'b0001;
      @(negedge clk);
      req_vld = '0; req_rdy_m = 1'b1;
      @(negedge clk);
      req_rdy_m = 1'b0; ack_vld_m = 1'b1; ack_rdy = 4'b0001;
      @(negedge clk);
      ack_vld_m = 1'b0; ack_rdy = '0;
      req_vld = 4'b0100; wr_en = 4'b0100; addr[2*AW +: AW] = 64'h99;
      @(negedge clk);
      req_vld = '0; wr_en = '0; req_rdy_m = 1'b1;
      @(negedge clk);
      req_rdy_m = 1'b0; ack_vld_m = 1'b1; ack_rdy = 4'b0;
      #1;
      n_chk++; if (ack_vld !== 4'b0100) begin n_err++; $display("FAIL midrst_pre_ack got=%0h exp=4", ack_vld); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%0h exp=0", busy); end
      n_chk++; if (ack_vld !== 4'b0) begin n_err++; $display("FAIL midrst_ack_vld got=%0h exp=0", ack_vld); end
      n_chk++; if (grant_id !== 4'd0 || addr_m !== 64'h0 || wr_en_m !== 1'b0) begin n_err++; $display("FAIL midrst_regs got=%0h/%0h/%0h exp=0/0/0", grant_id, addr_m, wr_en_m); end
      n_chk++; if (ack_rdy_m !== 1'b0 || req_vld_m !== 1'b0) begin n_err++; $display("FAIL midrst_m got=%0h/%0h exp=0/0", ack_rdy_m, req_vld_m); end
      ack_vld_m = 1'b0;
      req_vld = 4'hF;
      #1;
      n_chk++; if (req_rdy !== 4'b0001) begin n_err++; $display("FAIL midrst_ptr0 got=%0h exp=1", req_rdy); end
      req_vld = '0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      clr_inputs();
      test_reset();
      test_single();
      test_order(4'b1111, 5, 0, 1, 2, 3, 0, "rr");
      test_stall();
      test_read_ack_stall();
      test_reset_mid();
      test_order(4'b1001, 4, 0, 3, 0, 3, 0, "alt");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/mst_req_arb.md
MST_REQ_ARB -- requirements
Module: mst_req_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, address width of every request path SHALL be this value.
REQ-002 Parameter DATA_WIDTH, default 32, write and read data width SHALL be this value.
REQ-003 Parameter N, default 4, range 1..16, number of upstream requesters SHALL be this value.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_vld / req_rdy  input / output  N  per-requester request handshake.
REQ-007 rd_en, wr_en  input  N  per-requester access type.
REQ-008 addr / wr_data  input  N*ADDR_WIDTH / N*DATA_WIDTH  packed per-requester payload; slice i belongs to requester i.
REQ-009 ack_vld / ack_rdy  output / input  N  per-requester completion handshake.
REQ-010 rd_data  output  DATA_WIDTH  read data, shared by all requesters, qualified by ack_vld[i].
REQ-011 req_vld_m / req_rdy_m  output / input  1  downstream request handshake toward mst_fsm.
REQ-012 rd_en_m, wr_en_m, addr_m, wr_data_m  output  1, 1, ADDR_WIDTH, DATA_WIDTH  downstream payload, registered.
REQ-013 ack_vld_m / ack_rdy_m  input / output  1  downstream completion handshake; rd_data_m input DATA_WIDTH.
REQ-014 grant_id  output  4  index of current owner; busy  output  1  high outside IDLE.

Function
REQ-015 FSM states SHALL be IDLE, REQ, ACK; exactly one transaction in flight.
- IDLE: when any req_vld is high, select winner g, go to REQ next cycle. With no req_vld, stay in IDLE.
- REQ: hold req_vld_m=1; on req_vld_m&req_rdy_m, go to ACK.
- ACK: on ack_vld_m&ack_rdy[g], go to IDLE.
REQ-016 Selection: round-robin from pointer ptr. Winner = first i with req_vld[i]=1 searching ptr, ptr+1, ... modulo N. Wrap N-1 -> 0.
REQ-017 ptr SHALL update to (g+1) mod N only on ACK completion. An aborted transaction (reset) SHALL not update ptr.
REQ-018 On the IDLE->REQ cycle, the block SHALL:
- pulse req_rdy[g] for exactly one cycle;
- capture rd_en[g], wr_en[g], addr slice g and wr_data slice g into the *_m registers;
- register g into grant_id.
REQ-019 req_rdy[i] SHALL be 0 for i!=g and in all other cycles. Upstream changes after capture SHALL not affect the *_m outputs.
REQ-020 Latency: req_vld[g] rising in IDLE -> req_vld_m=1 on the next cycle. Downstream payload SHALL be stable while req_vld_m=1 and req_rdy_m=0.
REQ-021 In ACK, ack_rdy_m SHALL equal ack_rdy[g] (combinational), and ack_vld[g] SHALL equal ack_vld_m. rd_data SHALL equal rd_data_m, passed through combinationally. ack_vld[i]=0 for i!=g.
REQ-022 A request arriving while busy SHALL wait. Arbitration SHALL occur only in IDLE, giving one bubble cycle between back-to-back transactions.
REQ-023 A simultaneous req_vld_m&req_rdy_m and ack_vld_m in the same cycle is not legal from mst_fsm. The block SHALL ignore ack_vld_m outside ACK.
REQ-024 When N=1, the block SHALL degenerate to a registered pass-through with grant_id=0.

Reset
REQ-025 While rst=1, the block SHALL force the following on the next clk edge:
- state to IDLE and ptr to 0;
- grant_id, req_vld_m, rd_en_m, wr_en_m, addr_m and wr_data_m to 0;
- req_rdy, ack_vld and ack_rdy_m to 0, and busy to 0.
REQ-026 Reset asserted mid-transaction SHALL drop the transaction with no ack to the requester. The first cycle after rst deasserts SHALL be IDLE.

Configuration
REQ-027 Macro MST_REQ_ARB_PRIO0_EN:
- defined: requester 0 SHALL win whenever req_vld[0]=1 in IDLE, and all others SHALL use round-robin among themselves;
- undefined: pure round-robin per REQ-016.

Verification
REQ-028 N=4, single request: req_vld[2]=1, addr=0x40, wr_en=1, wr_data=0xA5A5A5A5 -> next cycle req_vld_m=1, addr_m=0x40, grant_id=2, req_rdy[2] one-cycle pulse.
REQ-029 All four requesting, ptr=0, every access completes -> grant order 0,1,2,3,0 with one IDLE bubble between them.
REQ-030 req_rdy_m held low 5 cycles -> req_vld_m and addr_m stable for 5 cycles. Upstream addr changed to 0xFF meanwhile -> addr_m unchanged.
REQ-031 Read by requester 1, ack_vld_m=1 with rd_data_m=0xDEADBEEF and ack_rdy[1]=0 for 3 cycles -> ack_vld[1]=1 and rd_data=0xDEADBEEF held, no state change until ack_rdy[1]=1, then IDLE and ptr=2.
REQ-032 rst pulsed in ACK -> next cycle IDLE, ptr=0, all outputs 0, no ack_vld to the owner.
REQ-033 With MST_REQ_ARB_PRIO0_EN defined and requesters 0 and 3 continuously requesting -> grants always 0. Without it -> grants alternate 0,3,0,3.
